hazard_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding controller for the pipelined CPU. Sits beside the ID stage.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 96 +++++++++
 tb/tb_hazard_scoreboard.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: ID-stage operand request, in-flight stage results,
// and the returned forwarding selects / operands / stall.
interface hazard_scoreboard_if #(
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2
);
  localparam int SW = $clog2(DEPTH + 1);

  logic                  id_valid;
  logic                  id_we;
  logic                  id_is_load;
  logic [AW-1:0]         id_rd;
  logic [NSRC*AW-1:0]    id_src;
  logic [NSRC-1:0]       id_src_used;
  logic                  flush;
  logic [DEPTH*DW-1:0]   stage_data;
  logic [NSRC*DW-1:0]    rf_data;
  logic                  stall;
  logic [NSRC*SW-1:0]    fwd_sel;
  logic [NSRC*DW-1:0]    fwd_data;

  // ID stage / pipeline side
  modport master (
    output id_valid, id_we, id_is_load, id_rd, id_src, id_src_used, flush,
           stage_data, rf_data,
    input  stall, fwd_sel, fwd_data
  );

  // Scoreboard side
  modport slave (
    input  id_valid, id_we, id_is_load, id_rd, id_src, id_src_used, flush,
           stage_data, rf_data,
    output stall, fwd_sel, fwd_data
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller sitting beside ID. Tracks destination tags of
// in-flight instructions through DEPTH stages (EX..WB), picks the youngest
// matching producer per source port, and stalls on load-use.
// Optional feature macro: HZ_PERF_EN adds saturating perf_stalls/perf_fwds.
module hazard_scoreboard #(
  parameter int AW         = 4,
  parameter int DW         = 32,
  parameter int DEPTH      = 3,
  parameter int NSRC       = 2,
  parameter int LOAD_STAGE = 1
) (
  input  logic clk,
  input  logic R,
  hazard_scoreboard_if.slave bus
`ifdef HZ_PERF_EN
  ,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_fwds
`endif
);
  localparam int SW = $clog2(DEPTH + 1);

  // Per-stage tags: valid is control (reset), rd/ld are payload (no reset)
  logic [DEPTH-1:0] vld_p;
  logic [AW-1:0]    rd_p [DEPTH];
  logic [DEPTH-1:0] ld_p;

  logic [NSRC*SW-1:0] sel_c;
  logic [NSRC*DW-1:0] data_c;
  logic [NSRC-1:0]    busy_c;
  logic               stall_c;
  logic               tag_new;

  // Match each source against every stage; scanning oldest to youngest so the
  // youngest producer is the last to overwrite the select.
  always_comb begin
    sel_c  = '0;
    data_c = bus.rf_data;
    busy_c = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (bus.id_src_used[i] && vld_p[k] &&
            (rd_p[k] == bus.id_src[i*AW +: AW])) begin
          sel_c[i*SW +: SW]  = SW'(k + 1);
          data_c[i*DW +: DW] = bus.stage_data[k*DW +: DW];
          busy_c[i]          = ld_p[k] && (k < LOAD_STAGE);
        end
      end
    end
  end

  // flush wins over stall; a stalled or flushed ID instruction becomes a bubble
  assign stall_c      = bus.id_valid & ~bus.flush & (|busy_c);
  assign tag_new      = bus.id_valid & bus.id_we & ~stall_c & ~bus.flush;
  assign bus.stall    = stall_c;
  assign bus.fwd_sel  = sel_c;
  assign bus.fwd_data = data_c;

  // Tag valid shift: EX..WB never freeze, the WB tag simply drops out
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= tag_new;
      for (int k = 1; k < DEPTH; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // Tag payload shift alongside the valid bits
  always_ff @(posedge clk) begin
    rd_p[0] <= bus.id_rd;
    ld_p[0] <= bus.id_is_load;
    for (int k = 1; k < DEPTH; k++) begin
      rd_p[k] <= rd_p[k-1];
      ld_p[k] <= ld_p[k-1];
    end
  end

`ifdef HZ_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Saturating event counters for stalls and forwarded issues
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      perf_stalls <= '0;
      perf_fwds   <= '0;
    end else begin
      if (stall_c) perf_stalls <= sat_inc(perf_stalls);
      if (!stall_c && bus.id_valid && !bus.flush && (|sel_c))
        perf_fwds <= sat_inc(perf_fwds);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a table of per-cycle ID vectors with
// hand-computed stall/select expectations, plus hand sequences for youngest-wins,
// flush-vs-stall and asynchronous reset during a stall.
module tb_hazard_scoreboard;
  localparam int AW = 4, DW = 32, DEPTH = 3, NSRC = 2, SW = 2;

  logic clk = 1'b0;
  logic R   = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .NSRC(NSRC)) bus ();

`ifdef HZ_PERF_EN
  logic [31:0] perf_stalls, perf_fwds;
`endif

  hazard_scoreboard #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .NSRC(NSRC), .LOAD_STAGE(1)) dut (
    .clk(clk),
    .R(R),
    .bus(bus.slave)
`ifdef HZ_PERF_EN
    ,
    .perf_stalls(perf_stalls),
    .perf_fwds(perf_fwds)
`endif
  );

  logic [DW-1:0] sd [DEPTH];
  logic [DW-1:0] rf [NSRC];
  assign bus.stage_data = {sd[2], sd[1], sd[0]};
  assign bus.rf_data    = {rf[1], rf[0]};

  typedef struct {
    logic       valid, we, ld;
    logic [3:0] rd, s0, s1;
    logic [1:0] used;
    logic       fl;
    logic       stall;
    logic [1:0] sel0, sel1;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t tbl [18];

  function automatic vec_t mk(input logic valid, we, ld, input logic [3:0] rd, s0, s1,
                              input logic [1:0] used, input logic fl, stall,
                              input logic [1:0] sel0, sel1);
    vec_t v;
    v.valid = valid; v.we = we; v.ld = ld; v.rd = rd; v.s0 = s0; v.s1 = s1;
    v.used = used; v.fl = fl; v.stall = stall; v.sel0 = sel0; v.sel1 = sel1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid    = v.valid;
    bus.id_we       = v.we;
    bus.id_is_load  = v.ld;
    bus.id_rd       = v.rd;
    bus.id_src      = {v.s1, v.s0};
    bus.id_src_used = v.used;
    bus.flush       = v.fl;
  endtask

  function automatic logic [DW-1:0] exp_data(input int port, input logic [1:0] sel);
    return (sel == 2'd0) ? rf[port] : sd[sel - 2'd1];
  endfunction

  // stall always checked; selects and operands only when no stall is expected
  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, "_stall"}, {31'd0, bus.stall}, {31'd0, v.stall});
    if (!v.stall) begin
      chk({tag, "_sel0"}, {30'd0, bus.fwd_sel[SW-1:0]}, {30'd0, v.sel0});
      chk({tag, "_sel1"}, {30'd0, bus.fwd_sel[2*SW-1:SW]}, {30'd0, v.sel1});
      chk({tag, "_data0"}, bus.fwd_data[DW-1:0], exp_data(0, v.sel0));
      chk({tag, "_data1"}, bus.fwd_data[2*DW-1:DW], exp_data(1, v.sel1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    R = 1'b0;
    drive(mk(0,0,0, 0,0,0, 2'b00, 0, 0, 0,0));
    #1;
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    R = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) sd[k] = 32'hA0A0_0000 | k;
    for (int i = 0; i < NSRC; i++) rf[i] = 32'hB0B0_0000 | i;

    //            vld we ld  rd  s0  s1  used  fl stall sel0 sel1
    for (int i = 0; i < 5; i++)
      tbl[i] = mk(0, 0, 0,  0,  0,  0, 2'b00, 0, 0,    0,   0);  // idle after reset
    tbl[5]  = mk(1, 1, 0,  1,  2,  3, 2'b11, 0, 0,    0,   0);  // ADD r1
    tbl[6]  = mk(1, 1, 0,  2,  1,  3, 2'b11, 0, 0,    1,   0);  // ADD r2,r1,r3
    tbl[7]  = mk(1, 1, 1,  4,  2,  0, 2'b01, 0, 0,    1,   0);  // LDR r4,[r2]
    tbl[8]  = mk(1, 1, 0,  5,  4,  4, 2'b11, 0, 1,    0,   0);  // ADD r5,r4,r4 stalls
    tbl[9]  = mk(1, 1, 0,  5,  4,  4, 2'b11, 0, 0,    2,   2);  // retry: from MEM
    tbl[10] = mk(1, 1, 0,  7,  4,  5, 2'b11, 0, 0,    3,   1);  // r4 from WB, r5 from EX
    tbl[11] = mk(1, 0, 0,  9,  4,  7, 2'b11, 0, 0,    0,   1);  // r4 retired, no tag made
    tbl[12] = mk(1, 1, 0,  0,  9,  5, 2'b11, 0, 0,    0,   3);  // r9 never tagged
    tbl[13] = mk(1, 0, 0,  0,  0,  7, 2'b11, 0, 0,    1,   3);  // r0 forwards normally
    tbl[14] = mk(1, 0, 0,  0,  0,  0, 2'b00, 0, 0,    0,   0);  // unused ports never match
    tbl[15] = mk(0, 0, 0,  0,  0,  0, 2'b01, 0, 0,    3,   0);  // r0 now in WB
    tbl[16] = mk(1, 1, 1,  8,  0,  0, 2'b00, 0, 0,    0,   0);  // LDR r8
    tbl[17] = mk(0, 0, 0,  0,  8,  0, 2'b01, 0, 0,    1,   0);  // invalid ID never stalls

    drive(mk(1,1,1, 3,3,3, 2'b11, 0, 0, 0,0));
    @(negedge clk);
    #1;
    chk("reset_stall", {31'd0, bus.stall}, 32'd0);
    chk("reset_sel", {28'd0, bus.fwd_sel}, 32'd0);
    chk("reset_data0", bus.fwd_data[DW-1:0], rf[0]);
    drive(mk(0,0,0, 0,0,0, 2'b00, 0, 0, 0,0));
    @(negedge clk);
    R = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_vec($sformatf("v%0d", i), tbl[i]);
    end

`ifdef HZ_PERF_EN
    @(negedge clk);
    drive(mk(0,0,0, 0,0,0, 2'b00, 0, 0, 0,0));
    #1;
    chk("perf_stalls", perf_stalls, 32'd1);
    chk("perf_fwds", perf_fwds, 32'd7);
`endif

    // Youngest producer wins: two writes of r6, then a reader
    do_reset();
    @(negedge clk); drive(mk(1,1,0, 6,0,0, 2'b00, 0, 0, 0,0));
    @(negedge clk); drive(mk(1,1,0, 6,0,0, 2'b00, 0, 0, 0,0));
    @(negedge clk);
    sd[0] = 32'd9; sd[1] = 32'd5;
    drive(mk(1,1,0, 7,6,0, 2'b01, 0, 0, 0,0));
    #1;
    chk("young_stall", {31'd0, bus.stall}, 32'd0);
    chk("young_sel0", {30'd0, bus.fwd_sel[SW-1:0]}, 32'd1);
    chk("young_data0", bus.fwd_data[DW-1:0], 32'd9);
`ifdef HZ_PERF_EN
    @(negedge clk);
    drive(mk(0,0,0, 0,0,0, 2'b00, 0, 0, 0,0));
    #1;
    chk("young_perf_fwds", perf_fwds, 32'd1);
`endif

    // Flush beats a load-use stall and the flushed instruction leaves a bubble
    do_reset();
    @(negedge clk); drive(mk(1,1,1, 4,0,0, 2'b00, 0, 0, 0,0));
    @(negedge clk); drive(mk(1,1,0, 5,4,0, 2'b01, 1, 0, 0,0));
    #1;
    chk("flush_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk); drive(mk(1,0,0, 0,5,4, 2'b11, 0, 0, 0,0));
    #1;
    chk("flush_bubble_sel0", {30'd0, bus.fwd_sel[SW-1:0]}, 32'd0);
    chk("flush_ld_sel1", {30'd0, bus.fwd_sel[2*SW-1:SW]}, 32'd2);
    chk("flush_after_stall", {31'd0, bus.stall}, 32'd0);

    // Asynchronous reset in the middle of a load-use stall
    do_reset();
    @(negedge clk); drive(mk(1,1,1, 4,0,0, 2'b00, 0, 0, 0,0));
    @(negedge clk); drive(mk(1,1,0, 5,4,0, 2'b01, 0, 0, 0,0));
    #1;
    chk("arst_pre_stall", {31'd0, bus.stall}, 32'd1);
    #1;
    R = 1'b0;
    #1;
    chk("arst_stall", {31'd0, bus.stall}, 32'd0);
    chk("arst_sel0", {30'd0, bus.fwd_sel[SW-1:0]}, 32'd0);
`ifdef HZ_PERF_EN
    chk("arst_perf", perf_stalls, 32'd0);
`endif
    @(negedge clk);
    R = 1'b1;
    #1;
    chk("arst_post_stall", {31'd0, bus.stall}, 32'd0);
    chk("arst_post_data0", bus.fwd_data[DW-1:0], rf[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
